rx_fifo_param: RTL and testbench
================================

// Module: rx_fifo_param
// PURPOSE
// - Parametrised single-clock receive FIFO between the UART RX shifter and the CPU/bus read port.
// - Holds its own storage array; no external memory handshake.
// - Reports occupancy, a programmable threshold, sticky overflow and, optionally, a character timeout.
// PARAMETERS
// - DATA_W       8    width of each stored word
// - DEPTH        32   number of entries; power of 2, >= 2
// - RX_THRESH    16   thresh_hit asserts when level >= RX_THRESH; legal range 1..DEPTH
// - TIMEOUT_CYC  64   idle cycles before timeout asserts; >= 1; used only with the macro
// - Localparam AW = $clog2(DEPTH)
// PORTS
// - clk         in   1         single clock; all state changes on its rising edge
// - rst_n       in   1         asynchronous reset, active low
// - wr_en       in   1         write request from the RX shifter (RXdone pulse)
// - wr_data     in   DATA_W    received word
// - rd_en       in   1         read request from the CPU side
// - rd_data     out  DATA_W    registered read data
// - rd_valid    out  1         one-cycle pulse; rd_data was updated this cycle
// - full        out  1         level == DEPTH
// - notempty    out  1         level != 0
// - level       out  AW+1      current occupancy, 0..DEPTH
// - thresh_hit  out  1         level >= RX_THRESH
// - overflow    out  1         sticky: a write was rejected because the FIFO was full
// - ovf_clr     in   1         clears overflow
// - timeout     out  1         character timeout; tied to 0 without the macro
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, timeout=0.
//   - Hence full=0, notempty=0, thresh_hit=0. The storage array is not reset.
//   - Reset mid-operation discards all contents immediately.
// - Write accept: wr_acc = wr_en & !full.
//   - mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, AW bits, wraps DEPTH-1 -> 0.
// - Read accept: rd_acc = rd_en & notempty.
//   - rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wraps.
//   - rd_valid <= 1 on the next edge, else 0. Read latency is 1 cycle.
//   - rd_data holds its value when no read is accepted.
// - full and notempty are combinational from the registered level, i.e. evaluated pre-edge.
// - Level update (no other change allowed):
//   - wr_acc only: level+1.
//   - rd_acc only: level-1.
//   - Both in one cycle: unchanged.
// - Simultaneous events:
//   - Full + wr_en + rd_en: the read is accepted, the write is rejected and overflow is set.
//   - Empty + wr_en + rd_en: the write is accepted, the read is rejected and rd_valid stays 0. No bypass.
// - rd_en while empty: ignored; pointers, rd_data and level are unchanged.
// - overflow:
//   - Set on wr_en & full.
//   - Cleared on ovf_clr.
//   - Set wins if both occur in the same cycle.
// CONFIGURATION
// - Macro RX_FIFO_TIMEOUT_EN defined:
//   - tmo_cnt is a $clog2(TIMEOUT_CYC+1)-bit counter.
//   - tmo_cnt clears to 0 when !notempty or when wr_acc | rd_acc; otherwise it increments, saturating at TIMEOUT_CYC.
//   - timeout = (tmo_cnt == TIMEOUT_CYC), registered.
//   - timeout deasserts on the cycle after the next accepted access, or when the FIFO empties.
// - Macro undefined: no counter exists; timeout is constant 0.
// - All other behaviour is identical in both builds.
// TESTING
// - Reset, then 32 writes 0x00..0x1F, no reads -> full=1 after the 32nd edge, level=32, thresh_hit=1 from the 16th write.
// - Full, wr_en with 0xAA -> overflow=1, level stays 32; ovf_clr pulse -> overflow=0; then 32 reads return 0x00..0x1F in order, each with a rd_valid pulse 1 cycle after rd_en, and notempty=0 at the end.
// - Wrap: 20 writes, 20 reads, then 20 writes 0x40..0x53 -> reads return 0x40..0x53 with correct pointer wrap and level 20 -> 0.
// - Simultaneous rd_en+wr_en for 10 cycles at level 5 -> level stays 5 and data order is preserved; the same at level 0 -> no rd_valid, level becomes 1.
// - RX_FIFO_TIMEOUT_EN: 1 write then idle -> timeout=1 exactly 64 cycles after the write edge; one read -> timeout=0 next cycle; without the macro timeout stays 0.
// - Assert rst_n low with level=12 -> level, notempty, rd_valid, overflow and timeout are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rx_fifo_param_if.sv
// Bus bundle for rx_fifo_param: RX-shifter write side, CPU read side and status flags.
// master = the side issuing writes/reads; slave = the FIFO itself.
interface rx_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              notempty;
    logic [AW:0]       level;
    logic              thresh_hit;
    logic              overflow;
    logic              timeout;

    modport master (
        output wr_en, wr_data, rd_en, ovf_clr,
        input  rd_data, rd_valid, full, notempty, level, thresh_hit, overflow, timeout
    );

    modport slave (
        input  wr_en, wr_data, rd_en, ovf_clr,
        output rd_data, rd_valid, full, notempty, level, thresh_hit, overflow, timeout
    );
endinterface

// File: rtl/rx_fifo_param.sv
// rx_fifo_param: single-clock receive FIFO between the UART RX shifter and the bus read port.
// Character timeout is built only when RX_FIFO_TIMEOUT_EN is defined; otherwise timeout is 0.
module rx_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int RX_THRESH   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    rx_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_LVL = (AW+1)'(RX_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rx_fifo_param: DEPTH must be a power of 2 and at least 2");
    end
    if ((RX_THRESH < 1) || (RX_THRESH > DEPTH)) begin : g_bad_thresh
        $error("rx_fifo_param: RX_THRESH must lie in 1..DEPTH");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("rx_fifo_param: TIMEOUT_CYC must be at least 1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [AW:0]       level_q,    level_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;

    logic full;
    logic notempty;
    logic wr_acc;
    logic rd_acc;

    // Flags come from the registered level, so they describe the state before the edge.
    assign full     = (level_q == FULL_LVL);
    assign notempty = (level_q != '0);
    assign wr_acc   = bus.wr_en & ~full;
    assign rd_acc   = bus.rd_en & notempty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A rejected write sets the sticky flag even if a clear arrives in the same cycle.
        if (bus.wr_en && full) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    // Counts idle cycles while data sits unread; any access or an empty FIFO restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!notempty || wr_acc || rd_acc) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_d = (tmo_cnt_d == TMO_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.full       = full;
    assign bus.notempty   = notempty;
    assign bus.level      = level_q;
    assign bus.thresh_hit = (level_q >= THRESH_LVL);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_rx_fifo_param.sv
// Self-checking bench for rx_fifo_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_fifo_param;
    localparam int DATA_W      = 8;
    localparam int DEPTH       = 32;
    localparam int RX_THRESH   = 16;
    localparam int TIMEOUT_CYC = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    rx_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .RX_THRESH(RX_THRESH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a queue plus the registered outputs.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_rd_data;
    bit                m_rd_valid;
    bit                m_ovf;
    bit                m_tmo;
    int                m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_tmo      = 1'b0;
        m_idle     = 0;
    endtask

    task automatic model_step();
        int  n;
        bit  f, ne, wacc, racc;
        n    = mq.size();
        f    = (n == DEPTH);
        ne   = (n != 0);
        wacc = bus.wr_en && !f;
        racc = bus.rd_en && ne;
        if (racc) begin
            m_rd_data  = mq.pop_front();
            m_rd_valid = 1'b1;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (wacc) mq.push_back(bus.wr_data);
        if (bus.wr_en && f) m_ovf = 1'b1;
        else if (bus.ovf_clr) m_ovf = 1'b0;
`ifdef RX_FIFO_TIMEOUT_EN
        if (!ne || wacc || racc) m_idle = 0;
        else if (m_idle < TIMEOUT_CYC) m_idle++;
        m_tmo = (m_idle == TIMEOUT_CYC);
`else
        m_tmo = 1'b0;
`endif
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        chk("level",      32'(bus.level),      32'(n));
        chk("full",       32'(bus.full),       32'(n == DEPTH));
        chk("notempty",   32'(bus.notempty),   32'(n != 0));
        chk("thresh_hit", 32'(bus.thresh_hit), 32'(n >= RX_THRESH));
        chk("rd_valid",   32'(bus.rd_valid),   32'(m_rd_valid));
        chk("rd_data",    32'(bus.rd_data),    32'(m_rd_data));
        chk("overflow",   32'(bus.overflow),   32'(m_ovf));
        chk("timeout",    32'(bus.timeout),    32'(m_tmo));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input bit we, input logic [DATA_W-1:0] wd, input bit re, input bit clr);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.ovf_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_notempty", 32'(bus.notempty), 32'd0);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        compare_all();
        rst_n = 1'b1;

        // Fill to full with 0x00..0x1F.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
            chk("fill_level",  32'(bus.level),      32'(i + 1));
            chk("fill_thresh", 32'(bus.thresh_hit), 32'((i + 1) >= 16));
        end
        chk("fill_full", 32'(bus.full), 32'd1);

        // Overflow while full, then clear, then read back in order.
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set",   32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level),    32'd32);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            chk("rd_order_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd_order_data",  32'(bus.rd_data),  32'(i));
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("drained_notempty", 32'(bus.notempty), 32'd0);
        chk("idle_rd_valid",    32'(bus.rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("empty_read_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty_read_hold",  32'(bus.rd_data),  32'h1F);

        // Pointer wrap.
        for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_data",  32'(bus.rd_data), 32'(8'h40 + i));
            chk("wrap_level", 32'(bus.level),   32'(19 - i));
        end

        // Simultaneous read and write at level 5, then at level 0.
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DATA_W'(8'h90 + i), 1'b1, 1'b0);
            chk("rw5_level", 32'(bus.level), 32'd5);
        end
        drain();
        chk("rw5_last", 32'(bus.rd_data), 32'h99);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rw0_valid", 32'(bus.rd_valid), 32'd0);
        chk("rw0_level", 32'(bus.level),    32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("rw0_data", 32'(bus.rd_data), 32'h77);

        // Character timeout.
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef RX_FIFO_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("tmo_edge", 32'(bus.timeout), 32'(k == TIMEOUT_CYC));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("tmo_clear", 32'(bus.timeout), 32'd0);
`else
        for (int k = 1; k <= TIMEOUT_CYC + 6; k++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("tmo_off", 32'(bus.timeout), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
`endif

        // Randomized traffic with varying bias so both full and empty are reached.
        for (int ph = 0; ph < 4; ph++) begin
            int wp, rp;
            wp = (ph == 0) ? 85 : (ph == 1) ? 25 : (ph == 2) ? 50 : 95;
            rp = (ph == 0) ? 25 : (ph == 1) ? 85 : (ph == 2) ? 50 : 10;
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 99) < wp, DATA_W'($urandom),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 5);
            end
        end
        drain();

        // Asynchronous reset with data held.
        for (int i = 0; i < 13; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level",    32'(bus.level),    32'd0);
        chk("arst_notempty", 32'(bus.notempty), 32'd0);
        chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("arst_overflow", 32'(bus.overflow), 32'd0);
        chk("arst_timeout",  32'(bus.timeout),  32'd0);
        model_reset();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_data", 32'(bus.rd_data), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
